pc_fetch_sequencer: RTL and testbench

Owns the architectural program counter and sequences instruction fetch for the pipelined core. Issues one request at a time to instruction memory and holds each fetched word in a single-entry IF output slot. Applies redirects from the branch-resolution logic (the target PC is computed by the PC/branch-offset datapath). Sits between instruction memory and the IF/ID pipeline register.

---
 rtl/pc_fetch_sequencer_if.sv | 10 +
 rtl/pc_fetch_sequencer.sv | 124 ++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_sequencer_if.sv
// Instruction-memory fetch bus: one outstanding request, held until acknowledged.
interface pc_fetch_sequencer_if;
  logic        req;
  logic [63:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/pc_fetch_sequencer.sv
// Program counter owner and instruction-fetch sequencer feeding a single-entry IF slot.
// Handles redirects (with in-flight request discard), stall back-pressure and misaligned-target halt.
module pc_fetch_sequencer #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         stall_i,
  input  logic                         redirect_valid,
  input  logic [63:0]                  redirect_pc,
  pc_fetch_sequencer_if.master         imem,
  output logic                         if_valid,
  output logic [63:0]                  if_pc,
  output logic [31:0]                  if_instr,
  output logic                         fetch_fault
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StHold,
    StDiscard,
    StHalt
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] pend_q, pend_d;
  logic        if_valid_q, if_valid_d;
  logic [63:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic        fault_q, fault_d;
  logic        slot_free;

  assign slot_free = ~if_valid_q | ~stall_i;

  // The address is always the PC; during DISCARD the PC is left at the abandoned address.
  assign imem.req  = (state_q == StFetch) || (state_q == StDiscard);
  assign imem.addr = pc_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    if_valid_d = if_valid_q & stall_i;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    fault_d    = fault_q;

    unique case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        if (imem.ack) begin
          if (slot_free) begin
            if_valid_d = 1'b1;
            if_pc_d    = pc_q;
            if_instr_d = imem.rdata;
            pc_d       = pc_q + 64'(PC_STEP);
            // Slot will be full while stalled: don't start the next request yet.
            if (stall_i) state_d = StHold;
          end else begin
            // Data refused; the same address is re-requested once the slot drains.
            state_d = StHold;
          end
        end
      end
      StHold: begin
        if (!stall_i) state_d = StFetch;
      end
      StDiscard: begin
        if (imem.ack) begin
          pc_d    = pend_q;
          state_d = StFetch;
        end
      end
      StHalt: if_valid_d = 1'b0;
      default: state_d = StIdle;
    endcase

    if (redirect_valid && (state_q != StHalt)) begin
      if_valid_d = 1'b0;
      if_pc_d    = if_pc_q;
      if_instr_d = if_instr_q;
      if (redirect_pc[1:0] != 2'b00) begin
        fault_d = 1'b1;
        state_d = StHalt;
      end else if (((state_q == StFetch) || (state_q == StDiscard)) && !imem.ack) begin
        // Request still outstanding: keep the address stable, retarget after the ack.
        pend_d  = redirect_pc;
        state_d = StDiscard;
      end else begin
        pc_d    = redirect_pc;
        state_d = StFetch;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      pend_q     <= 64'h0;
      if_valid_q <= 1'b0;
      if_pc_q    <= 64'h0;
      if_instr_q <= 32'h0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      fault_q    <= fault_d;
    end
  end

  assign if_valid    = if_valid_q;
  assign if_pc       = if_pc_q;
  assign if_instr    = if_instr_q;
  assign fetch_fault = fault_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed and randomized bench for pc_fetch_sequencer with an in-order fetch-stream model.
module tb_pc_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_i;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        if_valid;
  logic [63:0] if_pc;
  logic [31:0] if_instr;
  logic        fetch_fault;

  int errors = 0;
  int checks = 0;

  pc_fetch_sequencer_if imem ();

  pc_fetch_sequencer #(
    .RESET_PC(64'h0),
    .PC_STEP (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall_i       (stall_i),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem          (imem),
    .if_valid      (if_valid),
    .if_pc         (if_pc),
    .if_instr      (if_instr),
    .fetch_fault   (fetch_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [63:0] a);
    return (a[33:2] * 32'h9E37_79B9) ^ 32'h1357_2468;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock, then drive this cycle's inputs; memory data follows the current address.
  task automatic cyc(input logic st, input logic rv, input logic [63:0] rp, input logic ak);
    @(posedge clk);
    #1;
    stall_i        = st;
    redirect_valid = rv;
    redirect_pc    = rp;
    imem.ack       = ak;
    imem.rdata     = memf(imem.addr);
  endtask

  logic [63:0] exp_pc;
  logic [63:0] prev_addr;
  logic        prev_req, prev_ack;
  int          consumed;

  initial begin
    reset          = 1'b0;
    stall_i        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'h0;
    imem.ack       = 1'b0;
    imem.rdata     = 32'h0;
    #2;
    chk("rst_req", 64'(imem.req), 64'h0);
    chk("rst_addr", imem.addr, 64'h0);
    chk("rst_valid", 64'(if_valid), 64'h0);
    chk("rst_if_pc", if_pc, 64'h0);
    chk("rst_instr", 64'(if_instr), 64'h0);
    chk("rst_fault", 64'(fetch_fault), 64'h0);

    // Zero-wait memory after reset release.
    @(posedge clk);
    #3;
    reset      = 1'b1;
    imem.ack   = 1'b1;
    imem.rdata = memf(imem.addr);
    chk("idle_req", 64'(imem.req), 64'h0);
    cyc(0, 0, 64'h0, 1);
    chk("zw_req0", 64'(imem.req), 64'h1);
    chk("zw_addr0", imem.addr, 64'h0);
    chk("zw_valid0", 64'(if_valid), 64'h0);
    cyc(0, 0, 64'h0, 1);
    chk("zw_valid1", 64'(if_valid), 64'h1);
    chk("zw_pc1", if_pc, 64'h0);
    chk("zw_addr1", imem.addr, 64'h4);
    cyc(0, 0, 64'h0, 1);
    chk("zw_pc2", if_pc, 64'h4);
    chk("zw_addr2", imem.addr, 64'h8);
    cyc(0, 0, 64'h0, 1);
    chk("zw_pc3", if_pc, 64'h8);
    chk("zw_instr3", 64'(if_instr), 64'(memf(64'h8)));

    // Ack delayed: request to 0x10 held for three cycles.
    cyc(0, 0, 64'h0, 0);
    chk("dly_pc", if_pc, 64'hC);
    chk("dly_addr0", imem.addr, 64'h10);
    chk("dly_req0", 64'(imem.req), 64'h1);
    cyc(0, 0, 64'h0, 0);
    chk("dly_addr1", imem.addr, 64'h10);
    chk("dly_valid1", 64'(if_valid), 64'h0);
    cyc(0, 0, 64'h0, 1);
    chk("dly_addr2", imem.addr, 64'h10);
    chk("dly_req2", 64'(imem.req), 64'h1);

    // Slot full with stall for four cycles.
    cyc(1, 0, 64'h0, 1);
    chk("dly_load_pc", if_pc, 64'h10);
    chk("dly_load_valid", 64'(if_valid), 64'h1);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 64'h0, 1);
      chk("hold_req", 64'(imem.req), 64'h0);
      chk("hold_instr", 64'(if_instr), 64'(memf(64'h10)));
      chk("hold_valid", 64'(if_valid), 64'h1);
    end
    cyc(0, 0, 64'h0, 1);
    chk("hold_req_last", 64'(imem.req), 64'h0);
    chk("hold_pc_last", if_pc, 64'h10);
    cyc(0, 0, 64'h0, 1);
    chk("resume_req", 64'(imem.req), 64'h1);
    chk("resume_addr", imem.addr, 64'h14);
    chk("resume_valid", 64'(if_valid), 64'h0);
    cyc(0, 0, 64'h0, 0);
    chk("resume_pc", if_pc, 64'h14);
    chk("resume_next_addr", imem.addr, 64'h18);

    // Redirect coincident with ack, then redirect while a request is pending.
    cyc(0, 1, 64'h20, 1);
    chk("co_addr", imem.addr, 64'h18);
    cyc(0, 0, 64'h0, 0);
    chk("co_valid", 64'(if_valid), 64'h0);
    chk("co_addr_new", imem.addr, 64'h20);
    chk("co_if_pc", if_pc, 64'h14);
    cyc(0, 1, 64'h400, 0);
    chk("pend_addr0", imem.addr, 64'h20);
    cyc(0, 0, 64'h0, 0);
    chk("pend_valid", 64'(if_valid), 64'h0);
    chk("pend_addr1", imem.addr, 64'h20);
    chk("pend_req1", 64'(imem.req), 64'h1);
    cyc(0, 0, 64'h0, 1);
    chk("pend_addr2", imem.addr, 64'h20);
    cyc(0, 0, 64'h0, 1);
    chk("pend_target", imem.addr, 64'h400);
    chk("pend_dropped", 64'(if_valid), 64'h0);
    cyc(1, 0, 64'h0, 1);
    chk("tgt_pc", if_pc, 64'h400);
    chk("tgt_instr", 64'(if_instr), 64'(memf(64'h400)));

    // Redirect while stalled in HOLD.
    cyc(1, 1, 64'h800, 0);
    chk("st_hold_req", 64'(imem.req), 64'h0);
    cyc(0, 0, 64'h0, 0);
    chk("st_valid", 64'(if_valid), 64'h0);
    chk("st_addr", imem.addr, 64'h800);

    // PC wrap at the top of the address space.
    cyc(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1);
    cyc(0, 0, 64'h0, 1);
    chk("wrap_addr0", imem.addr, 64'hFFFF_FFFF_FFFF_FFFC);
    cyc(0, 0, 64'h0, 0);
    chk("wrap_if_pc", if_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_addr1", imem.addr, 64'h0);
    chk("wrap_fault", 64'(fetch_fault), 64'h0);

    // Misaligned redirect halts until reset.
    cyc(0, 1, 64'h402, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'($urandom_range(0, 1)), 0, 64'h0, 1);
      chk("halt_fault", 64'(fetch_fault), 64'h1);
      chk("halt_req", 64'(imem.req), 64'h0);
      chk("halt_valid", 64'(if_valid), 64'h0);
    end
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("rst2_fault", 64'(fetch_fault), 64'h0);
    chk("rst2_req", 64'(imem.req), 64'h0);
    chk("rst2_addr", imem.addr, 64'h0);
    chk("rst2_valid", 64'(if_valid), 64'h0);

    // Randomized run checked against the expected in-order fetch stream.
    stall_i        = 1'b0;
    redirect_valid = 1'b0;
    imem.ack       = 1'b0;
    @(posedge clk);
    #3;
    reset     = 1'b1;
    exp_pc    = 64'h0;
    prev_req  = 1'b0;
    prev_ack  = 1'b0;
    prev_addr = 64'h0;
    consumed  = 0;
    for (int n = 0; n < 3000; n++) begin
      cyc(($urandom % 4) == 0, ($urandom % 16) == 0, 64'($urandom_range(0, 1023)) << 2, 1'b0);
      imem.ack = imem.req && (($urandom % 3) != 0);
      if (prev_req && !prev_ack) begin
        chk("rnd_req_held", 64'(imem.req), 64'h1);
        chk("rnd_addr_held", imem.addr, prev_addr);
      end
      if (redirect_valid) begin
        exp_pc = redirect_pc;
      end else if (if_valid && !stall_i) begin
        chk("rnd_if_pc", if_pc, exp_pc);
        chk("rnd_if_instr", 64'(if_instr), 64'(memf(exp_pc)));
        exp_pc = exp_pc + 64'd4;
        consumed++;
      end
      prev_req  = imem.req;
      prev_ack  = imem.ack;
      prev_addr = imem.addr;
    end
    chk("rnd_progress", 64'(consumed > 300), 64'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
